// File: rtl/multi_timer_pkg.sv
// Shared register map constants and control-bit layout for multi_timer.
package multi_timer_pkg;

  // Register offsets within a channel, and the channel stride
  localparam int unsigned CNT_OFS   = 0;
  localparam int unsigned LIM_OFS   = 4;
  localparam int unsigned CTL_OFS   = 8;
  localparam int unsigned CH_STRIDE = 16;

  // Shared prescaler register (only decoded when the prescaler is built in)
  localparam int unsigned PRESC_OFS   = 32'h100;
  localparam int unsigned PRESC_WIDTH = 16;

  // CTL register bit positions; readable width covers bits [6:0]
  localparam int unsigned READY_BIT    = 0;
  localparam int unsigned OVR_BIT      = 2;
  localparam int unsigned IE_BIT       = 4;
  localparam int unsigned EN_BIT       = 5;
  localparam int unsigned ONESHOT_BIT  = 6;
  localparam int unsigned CTL_RD_WIDTH = 7;

  // Absolute address of a register in channel ch
  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input int unsigned ch,
                                           input int unsigned ofs);
    return base + 32'(ch * CH_STRIDE) + 32'(ofs);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, limit, control bits and terminal-event logic.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_i,
  input  logic                    cnt_we_i,
  input  logic                    lim_we_i,
  input  logic                    ctl_we_i,
  input  logic [CNT_WIDTH-1:0]    wdata_i,
  output logic [CNT_WIDTH-1:0]    cnt_o,
  output logic [CNT_WIDTH-1:0]    lim_o,
  output logic [CTL_RD_WIDTH-1:0] ctl_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic ready_q, ready_d, ovr_q, ovr_d, ie_q, ie_d, en_q, en_d, oneshot_q, oneshot_d;
  logic inc_c, term_c;

  // Next-state: a CNT write beats counting; a terminal event beats a CTL clear
  always_comb begin
    inc_c     = en_q & tick_i & ~cnt_we_i;
    term_c    = inc_c && (lim_q != '0) && (cnt_q >= lim_q - CNT_WIDTH'(1));
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    ie_d      = ie_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;

    if (cnt_we_i)    cnt_d = wdata_i;
    else if (term_c) cnt_d = '0;
    else if (inc_c)  cnt_d = cnt_q + CNT_WIDTH'(1);

    if (lim_we_i) lim_d = wdata_i;

    if (ctl_we_i) begin
      ie_d      = wdata_i[IE_BIT];
      en_d      = wdata_i[EN_BIT];
      oneshot_d = wdata_i[ONESHOT_BIT];
      if (!wdata_i[READY_BIT]) ready_d = 1'b0;
      if (!wdata_i[OVR_BIT])   ovr_d   = 1'b0;
    end

    if (term_c) begin
      ovr_d   = ovr_d | ready_q;
      ready_d = 1'b1;
      if (oneshot_q) en_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      lim_q     <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ie_q      <= 1'b0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      ie_q      <= ie_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Register views for the read mux; undefined CTL bits read as 0
  always_comb begin
    cnt_o              = cnt_q;
    lim_o              = lim_q;
    ctl_o              = '0;
    ctl_o[READY_BIT]   = ready_q;
    ctl_o[OVR_BIT]     = ovr_q;
    ctl_o[IE_BIT]      = ie_q;
    ctl_o[EN_BIT]      = en_q;
    ctl_o[ONESHOT_BIT] = oneshot_q;
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel bus-mapped timer: address decode, shared tick, read mux, IRQ.
// Optional shared prescaler built when MULTI_TIMER_PRESCALE_EN is defined.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ABUS_WIDTH = 32,
  parameter int unsigned DBUS_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ABUS_WIDTH-1:0] aBus,
  inout  wire  [DBUS_WIDTH-1:0] dBus,
  input  logic                  wrtEn,
  output logic                  IRQ
);

  logic                    tick_c;
  logic [CNT_WIDTH-1:0]    wdata_c;
  logic [NUM_CH-1:0]       cnt_we_c, lim_we_c, ctl_we_c;
  logic [CNT_WIDTH-1:0]    ch_cnt [NUM_CH];
  logic [CNT_WIDTH-1:0]    ch_lim [NUM_CH];
  logic [CTL_RD_WIDTH-1:0] ch_ctl [NUM_CH];
  logic                    rd_hit_c;
  logic [DBUS_WIDTH-1:0]   rd_data_c;

  assign wdata_c = CNT_WIDTH'(dBus);

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PRESC_WIDTH-1:0] presc_q, presc_d, div_q, div_d;
  logic                   presc_we_c;

  // Shared divider: one tick when it reaches PRESC; a PRESC write restarts it
  always_comb begin
    tick_c  = (div_q == presc_q);
    presc_d = presc_q;
    div_d   = tick_c ? '0 : div_q + PRESC_WIDTH'(1);
    if (presc_we_c) begin
      presc_d = PRESC_WIDTH'(dBus);
      div_d   = '0;
    end
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
`else
  assign tick_c = 1'b1;
`endif

  // Exact-match decode for writes and the combinational read mux
  always_comb begin
    cnt_we_c  = '0;
    lim_we_c  = '0;
    ctl_we_c  = '0;
    rd_hit_c  = 1'b0;
    rd_data_c = '0;
`ifdef MULTI_TIMER_PRESCALE_EN
    presc_we_c = 1'b0;
    if (aBus == ABUS_WIDTH'(reg_addr(BASE_ADDR, 0, PRESC_OFS))) begin
      presc_we_c = wrtEn;
      rd_hit_c   = 1'b1;
      rd_data_c  = DBUS_WIDTH'(presc_q);
    end
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (aBus == ABUS_WIDTH'(reg_addr(BASE_ADDR, i, CNT_OFS))) begin
        cnt_we_c[i] = wrtEn;
        rd_hit_c    = 1'b1;
        rd_data_c   = DBUS_WIDTH'(ch_cnt[i]);
      end
      if (aBus == ABUS_WIDTH'(reg_addr(BASE_ADDR, i, LIM_OFS))) begin
        lim_we_c[i] = wrtEn;
        rd_hit_c    = 1'b1;
        rd_data_c   = DBUS_WIDTH'(ch_lim[i]);
      end
      if (aBus == ABUS_WIDTH'(reg_addr(BASE_ADDR, i, CTL_OFS))) begin
        ctl_we_c[i] = wrtEn;
        rd_hit_c    = 1'b1;
        rd_data_c   = DBUS_WIDTH'(ch_ctl[i]);
      end
    end
  end

  // Bus is driven only for a mapped read
  assign dBus = (rd_hit_c && !wrtEn) ? rd_data_c : 'z;

  // Interrupt: any channel with READY and IE both set
  always_comb begin
    IRQ = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      IRQ = IRQ | (ch_ctl[i][READY_BIT] & ch_ctl[i][IE_BIT]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick_c),
      .cnt_we_i (cnt_we_c[g]),
      .lim_we_i (lim_we_c[g]),
      .ctl_we_i (ctl_we_c[g]),
      .wdata_i  (wdata_c),
      .cnt_o    (ch_cnt[g]),
      .lim_o    (ch_lim[g]),
      .ctl_o    (ch_ctl[g])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Randomized bench for multi_timer against a register-level reference model.
module tb_multi_timer;

  localparam int unsigned NCH  = 4;
  localparam logic [31:0] BASE = 32'hF000_0200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_bus;
  logic        wrt_en;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  logic        irq;
  tri1  [31:0] dbus_w;

  assign dbus_w = tb_drv ? tb_wdata : 'z;

  always #5 clk = ~clk;

  multi_timer #(
    .NUM_CH    (NCH),
    .CNT_WIDTH (32),
    .ABUS_WIDTH(32),
    .DBUS_WIDTH(32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .aBus (a_bus),
    .dBus (dbus_w),
    .wrtEn(wrt_en),
    .IRQ  (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, one entry per channel
  logic [31:0] m_cnt [NCH];
  logic [31:0] m_lim [NCH];
  logic        m_rdy [NCH];
  logic        m_ovr [NCH];
  logic        m_ie  [NCH];
  logic        m_en  [NCH];
  logic        m_os  [NCH];
  logic [15:0] m_presc;
  logic [15:0] m_div;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch_addr(input int unsigned c, input int unsigned r);
    return BASE + 32'(16 * c) + 32'(4 * r);
  endfunction

  task automatic m_reset();
    for (int unsigned c = 0; c < NCH; c++) begin
      m_cnt[c] = '0; m_lim[c] = '0; m_rdy[c] = 1'b0; m_ovr[c] = 1'b0;
      m_ie[c] = 1'b0; m_en[c] = 1'b0; m_os[c] = 1'b0;
    end
    m_presc = '0;
    m_div   = '0;
  endtask

  // Expected bus value for a read; an undriven bus reads as all ones (pull-up)
  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (a == ch_addr(c, 0)) v = m_cnt[c];
      if (a == ch_addr(c, 1)) v = m_lim[c];
      if (a == ch_addr(c, 2))
        v = {25'd0, m_os[c], m_en[c], m_ie[c], 1'b0, m_ovr[c], 1'b0, m_rdy[c]};
    end
`ifdef MULTI_TIMER_PRESCALE_EN
    if (a == BASE + 32'h100) v = {16'd0, m_presc};
`endif
    return v;
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) r = r | (m_rdy[c] & m_ie[c]);
    return r;
  endfunction

  // Apply one clock edge of the timer rules to the model
  task automatic m_step(input logic [31:0] a, input logic we, input logic [31:0] d);
    logic tick, wc, wl, wt, adv, hit, was_rdy, was_os;
`ifdef MULTI_TIMER_PRESCALE_EN
    tick = (m_div == m_presc);
`else
    tick = 1'b1;
`endif
    for (int unsigned c = 0; c < NCH; c++) begin
      wc = we && (a == ch_addr(c, 0));
      wl = we && (a == ch_addr(c, 1));
      wt = we && (a == ch_addr(c, 2));
      adv = m_en[c] && tick && !wc;
      hit = adv && (m_lim[c] != 0) && (m_cnt[c] >= m_lim[c] - 32'd1);
      was_rdy = m_rdy[c];
      was_os  = m_os[c];
      if (wc) m_cnt[c] = d;
      else if (hit) m_cnt[c] = 0;
      else if (adv) m_cnt[c] = m_cnt[c] + 32'd1;
      if (wl) m_lim[c] = d;
      if (wt) begin
        m_ie[c] = d[4]; m_en[c] = d[5]; m_os[c] = d[6];
        if (!d[0]) m_rdy[c] = 1'b0;
        if (!d[2]) m_ovr[c] = 1'b0;
      end
      if (hit) begin
        if (was_rdy) m_ovr[c] = 1'b1;
        m_rdy[c] = 1'b1;
        if (was_os) m_en[c] = 1'b0;
      end
    end
`ifdef MULTI_TIMER_PRESCALE_EN
    if (we && a == BASE + 32'h100) begin
      m_presc = d[15:0];
      m_div   = '0;
    end else if (tick) m_div = '0;
    else m_div = m_div + 16'd1;
`endif
  endtask

  // One bus cycle: drive after the edge, check at negedge, advance model at posedge
  task automatic op(input logic [31:0] a, input logic we, input logic [31:0] d,
                    output logic [31:0] obs);
    a_bus    = a;
    wrt_en   = we;
    tb_drv   = we;
    tb_wdata = d;
    @(negedge clk);
    obs = dbus_w;
    chk_eq("irq", 32'(irq), 32'(m_irq()));
    if (!we) chk_eq($sformatf("rd_%08h", a), obs, m_read(a));
    @(posedge clk);
    if (rst_n) m_step(a, we, d);
    else m_reset();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    op(a, 1'b1, d, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    op(a, 1'b0, 32'd0, v);
  endtask

  task automatic rand_ops(input int n);
    int unsigned c, r;
    logic [31:0] a, d, v;
    logic we;
    for (int i = 0; i < n; i++) begin
      c = $urandom_range(0, NCH - 1);
      r = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0: a = BASE + 32'h100;
        1: a = ch_addr(c, 3);
        2: a = ch_addr(NCH, 0);
        default: a = ch_addr(c, r);
      endcase
      we = ($urandom_range(0, 9) < 4);
      if (r == 0) d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8))
                                                   : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else if (r == 1) d = 32'($urandom_range(0, 6));
      else d = 32'($urandom_range(0, 127)) | (($urandom_range(0, 1) == 0) ? 32'h20 : 32'h0);
      if (a == BASE + 32'h100) d = 32'($urandom_range(0, 3));
      op(a, we, d, v);
    end
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b0; a_bus = '0; wrt_en = 1'b0; tb_drv = 1'b0; tb_wdata = '0;
    m_reset();
    @(posedge clk); #1;
    // Reset state of every register
    for (int unsigned c = 0; c < NCH; c++)
      for (int unsigned r = 0; r < 3; r++) rd(ch_addr(c, r), v);
    rst_n = 1'b1;

    // Ch0 periodic, LIM=5, IE=0
    wr(ch_addr(0, 1), 32'd5);
    wr(ch_addr(0, 2), 32'h20);
    for (int i = 0; i < 5; i++) begin
      rd(ch_addr(0, 0), v);
      chk_eq("ch0_seq", v, 32'(i));
    end
    rd(ch_addr(0, 0), v); chk_eq("ch0_wrap", v, 32'd0);
    rd(ch_addr(0, 2), v); chk_eq("ch0_ready", v, 32'h21);
    chk_eq("ch0_irq", 32'(irq), 32'd0);

    // Ch1 one-shot with interrupt
    wr(ch_addr(1, 1), 32'd3);
    wr(ch_addr(1, 2), 32'h70);
    for (int i = 0; i < 3; i++) begin
      rd(ch_addr(1, 0), v);
      chk_eq("ch1_seq", v, 32'(i));
    end
    rd(ch_addr(1, 2), v); chk_eq("ch1_ctl", v, 32'h51);
    chk_eq("ch1_irq", 32'(irq), 32'd1);
    rd(ch_addr(1, 0), v); chk_eq("ch1_hold0", v, 32'd0);
    rd(ch_addr(1, 0), v); chk_eq("ch1_hold1", v, 32'd0);
    wr(ch_addr(1, 2), 32'h00);
    chk_eq("ch1_irq_clr", 32'(irq), 32'd0);

    // Ch2 overrun, then a clear colliding with an event
    wr(ch_addr(2, 1), 32'd4);
    wr(ch_addr(2, 2), 32'h20);
    for (int i = 0; i < 9; i++) rd(ch_addr(2, 0), v);
    rd(ch_addr(2, 2), v); chk_eq("ch2_ovr", v, 32'h25);
    rd(ch_addr(2, 0), v); chk_eq("ch2_cnt", v, 32'd2);
    wr(ch_addr(2, 2), 32'h20);
    rd(ch_addr(2, 2), v); chk_eq("ch2_evt_wins", v, 32'h25);
    wr(ch_addr(2, 2), 32'h20);
    rd(ch_addr(2, 2), v); chk_eq("ch2_clear", v, 32'h20);

    // Ch3 free-run: CNT load and full-width wrap
    wr(ch_addr(3, 2), 32'h20);
    for (int i = 0; i < 3; i++) rd(ch_addr(3, 0), v);
    wr(ch_addr(3, 0), 32'h10);
    rd(ch_addr(3, 0), v); chk_eq("ch3_load", v, 32'h10);
    rd(ch_addr(3, 0), v); chk_eq("ch3_inc", v, 32'h11);
    wr(ch_addr(3, 0), 32'hFFFF_FFFF);
    rd(ch_addr(3, 0), v); chk_eq("ch3_max", v, 32'hFFFF_FFFF);
    rd(ch_addr(3, 0), v); chk_eq("ch3_wrap", v, 32'd0);
    rd(ch_addr(3, 2), v); chk_eq("ch3_no_evt", v, 32'h20);

`ifdef MULTI_TIMER_PRESCALE_EN
    // Prescaled tick: PRESC=3, LIM=2
    wr(ch_addr(0, 2), 32'h00);
    wr(ch_addr(0, 0), 32'd0);
    wr(ch_addr(0, 1), 32'd2);
    wr(BASE + 32'h100, 32'd3);
    wr(ch_addr(0, 2), 32'h20);
    for (int i = 0; i < 8; i++) begin
      rd(ch_addr(0, 2), v);
      chk_eq("presc_ready", v, (i < 7) ? 32'h20 : 32'h21);
    end
    wr(BASE + 32'h100, 32'd0);
`else
    rd(BASE + 32'h100, v); chk_eq("presc_unmapped", v, 32'hFFFF_FFFF);
`endif

    rand_ops(300);

    // Arm an interrupt on ch1, then reset mid-cycle
`ifdef MULTI_TIMER_PRESCALE_EN
    wr(BASE + 32'h100, 32'd0);
`endif
    wr(ch_addr(1, 2), 32'h00);
    wr(ch_addr(1, 0), 32'd0);
    wr(ch_addr(1, 1), 32'd2);
    wr(ch_addr(1, 2), 32'h30);
    rd(ch_addr(1, 0), v);
    rd(ch_addr(1, 0), v);
    chk_eq("pre_rst_irq", 32'(irq), 32'd1);
    a_bus = ch_addr(1, 2); wrt_en = 1'b0; tb_drv = 1'b0;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_eq("rst_irq_async", 32'(irq), 32'd0);
    chk_eq("rst_ctl_async", dbus_w, 32'd0);
    @(posedge clk); #1;
    for (int unsigned c = 0; c < NCH; c++)
      for (int unsigned r = 0; r < 3; r++) rd(ch_addr(c, r), v);
    rd(ch_addr(0, 3), v); chk_eq("unmapped_hiz", v, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    for (int unsigned c = 0; c < NCH; c++) begin
      rd(ch_addr(c, 2), v);
      chk_eq("post_rst_ctl", v, 32'd0);
    end

    rand_ops(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter CNT_WIDTH, default 32, counter/limit width (legal 8..32).
REQ-003 Parameter ABUS_WIDTH, default 32, address bus width.
REQ-004 Parameter DBUS_WIDTH, default 32, data bus width.
REQ-005 Parameter BASE_ADDR, default 32'hF0000200, block base address.
REQ-006 Port clk  input  1  sole clock; all state on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-low reset.
REQ-008 Port aBus  input  ABUS_WIDTH  register address.
REQ-009 Port dBus  inout  DBUS_WIDTH  data; driven only on a mapped read, else high-Z.
REQ-010 Port wrtEn  input  1  1 = write the addressed register this cycle, 0 = read.
REQ-011 Port IRQ  output  1  OR over channels of (READY & IE).

Function
REQ-012 Channel i registers SHALL be CNT at BASE_ADDR+16*i, LIM at +4, CTL at +8; exact-match decode.
REQ-013 CTL bits SHALL be: [0] READY, [2] OVR, [4] IE, [5] EN, [6] ONESHOT; all other bits read 0.
REQ-014 A channel SHALL increment CNT by 1 on each cycle where EN=1 and tick=1.
REQ-015 Terminal event SHALL occur on an increment cycle when LIM!=0 and CNT>=LIM-1: CNT<=0, READY<=1, OVR<=1 if READY was already 1, EN<=0 if ONESHOT=1.
REQ-016 With LIM=0 the counter SHALL free-run, wrapping 2^CNT_WIDTH-1 -> 0 with no event.
REQ-017 CNT write SHALL load dBus[CNT_WIDTH-1:0] and suppress that cycle's increment and terminal check.
REQ-018 LIM write SHALL take effect for the terminal check on the following cycle.
REQ-019 CTL write: IE, EN, ONESHOT load directly; READY and OVR cleared by writing 0, unaffected by writing 1.
REQ-020 Terminal event in the same cycle as a CTL write clearing READY/OVR: event wins, bits end set.
REQ-021 Reads SHALL be combinational: dBus = zero-extended register when address matches and wrtEn=0.
REQ-022 IRQ SHALL be combinational from registered READY/IE; it rises the cycle after a terminal event.
REQ-023 Unmapped addresses SHALL leave dBus high-Z and state unchanged.

Reset
REQ-024 On reset low: every CNT=0, LIM=0, CTL=0 (EN=0), prescaler state=0, IRQ=0, immediately and asynchronously.
REQ-025 Reset mid-count SHALL abort all channels; no event is generated on reset release.

Configuration
REQ-026 Macro MULTI_TIMER_PRESCALE_EN defined: PRESC register (16 bits) at BASE_ADDR+0x100; shared divider asserts tick for one cycle when divider==PRESC, then divider<=0; PRESC=0 gives tick every cycle; a PRESC write also clears the divider.
REQ-027 Macro undefined: tick=1 every cycle; BASE_ADDR+0x100 is unmapped.

Structure
REQ-028 Package multi_timer_pkg SHALL hold register offsets (CNT/LIM/CTL/PRESC), CTL bit indices and channel stride.
REQ-029 Sub-module timer_channel SHALL implement one channel (CNT, LIM, CTL, terminal logic), instantiated NUM_CH times by generate; top holds decode, prescaler, read mux, IRQ OR.

Verification
REQ-030 Ch0 LIM=5, CTL=0x20 -> READY set 5 cycles after enable; CNT sequence 0,1,2,3,4,0; IRQ stays 0 (IE=0).
REQ-031 Ch1 LIM=3, CTL=0x70 (IE,EN,ONESHOT) -> one event, IRQ=1, EN reads 0, CNT holds 0; write CTL=0x00 -> IRQ=0.
REQ-032 Ch2 LIM=4 periodic, no clear for 9 cycles -> CTL reads 0x25 (READY,OVR,EN); write CTL with bits 0,2=0 in event cycle -> READY,OVR remain 1.
REQ-033 CNT write 0x10 while counting -> reads 0x10 next cycle; LIM=0 with CNT=0xFFFFFFFF -> wraps to 0, READY unchanged.
REQ-034 With MULTI_TIMER_PRESCALE_EN, PRESC=3, LIM=2 -> READY after 8 clocks; without macro read of BASE_ADDR+0x100 -> dBus high-Z.
REQ-035 Assert reset mid-count on all channels -> all registers read 0, IRQ=0 within same cycle; unmapped read -> dBus high-Z.
